// File: rtl/baud_rate_gen.sv
// UART baud-tick generator: loadable divisor, oversample tick (tick_os) and bit tick (tick).
// Define BAUD_FRAC_EN to add the frac_in port and the fractional-divisor accumulator.
module baud_rate_gen #(
    parameter int DIV_W       = 16,
    parameter int OVERSAMPLE  = 16,
    parameter int DEFAULT_DIV = 20,
    parameter int FRAC_W      = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [DIV_W-1:0] div_in,
    input  logic             div_load,
`ifdef BAUD_FRAC_EN
    input  logic [FRAC_W-1:0] frac_in,
`endif
    output logic             tick_os,
    output logic             tick,
    output logic [DIV_W-1:0] div_cur
);

    localparam int OS_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [OS_W-1:0]  OS_LAST  = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]  OS_ONE   = OS_W'(1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_RST  = DIV_W'(DEFAULT_DIV);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] pre_q, pre_d;
    logic [OS_W-1:0]  os_q, os_d;
    logic             tick_os_q, tick_os_d;
    logic             tick_q, tick_d;
    logic [DIV_W-1:0] d_eff;
    logic [DIV_W-1:0] term_val;
    logic             terminal;

`ifdef BAUD_FRAC_EN
    logic [FRAC_W-1:0] frac_reg_q, frac_reg_d;
    logic [FRAC_W-1:0] frac_acc_q, frac_acc_d;
    logic              ext_q, ext_d;
    logic [FRAC_W:0]   frac_sum;
`endif

    // A stored divisor of zero behaves as one: tick_os every enabled cycle.
    always_comb begin
        d_eff = (div_q == '0) ? DIV_ONE : div_q;
`ifdef BAUD_FRAC_EN
        // ext_q stretches the current period by one cycle after an accumulator carry.
        term_val = ext_q ? d_eff : (d_eff - DIV_ONE);
        frac_sum = {1'b0, frac_acc_q} + {1'b0, frac_reg_q};
`else
        term_val = d_eff - DIV_ONE;
`endif
        terminal = (pre_q == term_val);
    end

    always_comb begin
        div_d     = div_q;
        pre_d     = pre_q;
        os_d      = os_q;
        tick_os_d = 1'b0;
        tick_d    = 1'b0;
`ifdef BAUD_FRAC_EN
        frac_reg_d = frac_reg_q;
        frac_acc_d = frac_acc_q;
        ext_d      = ext_q;
`endif
        if (div_load) begin
            div_d = div_in;
            pre_d = '0;
            os_d  = '0;
`ifdef BAUD_FRAC_EN
            frac_reg_d = frac_in;
            frac_acc_d = '0;
            ext_d      = 1'b0;
`endif
        end else if (en) begin
            if (terminal) begin
                pre_d     = '0;
                tick_os_d = 1'b1;
                tick_d    = (os_q == OS_LAST);
                os_d      = (os_q == OS_LAST) ? '0 : (os_q + OS_ONE);
`ifdef BAUD_FRAC_EN
                frac_acc_d = frac_sum[FRAC_W-1:0];
                ext_d      = frac_sum[FRAC_W];
`endif
            end else begin
                pre_d = pre_q + DIV_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= DIV_RST;
            pre_q     <= '0;
            os_q      <= '0;
            tick_os_q <= 1'b0;
            tick_q    <= 1'b0;
`ifdef BAUD_FRAC_EN
            frac_reg_q <= '0;
            frac_acc_q <= '0;
            ext_q      <= 1'b0;
`endif
        end else begin
            div_q     <= div_d;
            pre_q     <= pre_d;
            os_q      <= os_d;
            tick_os_q <= tick_os_d;
            tick_q    <= tick_d;
`ifdef BAUD_FRAC_EN
            frac_reg_q <= frac_reg_d;
            frac_acc_q <= frac_acc_d;
            ext_q      <= ext_d;
`endif
        end
    end

    assign tick_os = tick_os_q;
    assign tick    = tick_q;
    assign div_cur = div_q;

endmodule
